// File: rtl/linear_pair_collector_if.sv
// Pair-input and serial-output bus of linear_pair_collector.
// master is the collector's view; slave is the surrounding linear stage plus downstream sink.
interface linear_pair_collector_if #(
    parameter int DATA_W = 32
);
    logic              in_done;
    logic [DATA_W-1:0] in_d0;
    logic [DATA_W-1:0] in_d1;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  in_done, in_d0, in_d1, m_ready,
        output m_valid, m_data, m_last
    );

    modport slave (
        output in_done, in_d0, in_d1, m_ready,
        input  m_valid, m_data, m_last
    );
endinterface

// File: rtl/linear_pair_collector.sv
// Collects even/odd row float pairs into a row-ordered buffer, then replays the frame as a serial stream.
// Optional build macro COLLECT_NAN_FLAG_EN enables sticky NaN detection on accepted pairs.
module linear_pair_collector #(
    parameter int DATA_W    = 32,
    parameter int MAX_PAIRS = 32,
    parameter int LEN_W     = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        frame_len,
    linear_pair_collector_if.master bus,
    output logic                    collecting,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err,
    output logic                    overrun,
    output logic                    nan_seen
);
    localparam int               DEPTH   = 2 * MAX_PAIRS;
    localparam int               AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAIRS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  tgt_q;
    logic [LEN_W-1:0]  wr_cnt_q;
    logic [LEN_W:0]    rd_idx_q;
    logic [DATA_W-1:0] buf_mem [DEPTH];

    logic              len_ok;
    logic              start_ok;
    logic              start_bad;
    logic              wr_en;
    logic              xfer;
    logic              last_word;
    logic              stray_done;
    logic [LEN_W:0]    last_idx;
    logic [AW-1:0]     wr_idx0;
    logic [AW-1:0]     wr_idx1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        start_ok        = 1'b0;
        start_bad       = 1'b0;
        wr_en           = 1'b0;
        xfer            = 1'b0;
        stray_done      = 1'b0;
        len_ok          = (frame_len != '0) && (frame_len <= MAX_LEN);
        last_idx        = {tgt_q, 1'b0} - (LEN_W+1)'(1);
        last_word       = (rd_idx_q == last_idx);
        collecting      = (state_q == COLLECT);
        busy            = (state_q != IDLE);
        bus.m_valid     = (state_q == DRAIN);
        bus.m_last      = (state_q == DRAIN) && last_word;
        bus.m_data      = buf_mem[AW'(rd_idx_q)];
        case (state_q)
            IDLE: begin
                stray_done = bus.in_done;
                if (start) begin
                    if (len_ok) begin
                        start_ok = 1'b1;
                        state_d  = COLLECT;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.in_done) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == tgt_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                stray_done = bus.in_done;
                if (bus.m_ready) begin
                    xfer = 1'b1;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control counters and status flags; a stray pair in the start cycle still marks overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q      <= '0;
            wr_cnt_q   <= '0;
            rd_idx_q   <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= xfer && last_word;
            cfg_err    <= start_bad;
            if (start_ok) begin
                tgt_q    <= frame_len;
                wr_cnt_q <= '0;
                rd_idx_q <= '0;
                overrun  <= 1'b0;
            end
            if (stray_done) begin
                overrun <= 1'b1;
            end
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + LEN_W'(1);
            end
            if (xfer) begin
                rd_idx_q <= rd_idx_q + (LEN_W+1)'(1);
            end
        end
    end

    assign wr_idx0 = AW'({wr_cnt_q, 1'b0});
    assign wr_idx1 = wr_idx0 | AW'(1);

    // Buffer holds data only; its contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_idx0] <= bus.in_d0;
            buf_mem[wr_idx1] <= bus.in_d1;
        end
    end

`ifdef COLLECT_NAN_FLAG_EN
    function automatic logic is_nan(input logic [30:0] w);
        return (&w[30:23]) && (|w[22:0]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen <= 1'b0;
        end else if (start_ok) begin
            nan_seen <= 1'b0;
        end else if (wr_en && (is_nan(bus.in_d0[30:0]) || is_nan(bus.in_d1[30:0]))) begin
            nan_seen <= 1'b1;
        end
    end
`else
    assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_linear_pair_collector.sv
// Directed testbench for linear_pair_collector; NaN expectations follow COLLECT_NAN_FLAG_EN.
module tb_linear_pair_collector;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] frame_len;
    logic       collecting;
    logic       busy;
    logic       frame_done;
    logic       cfg_err;
    logic       overrun;
    logic       nan_seen;
    int         checks;
    int         errors;

    linear_pair_collector_if #(.DATA_W(32)) bus_if ();

    linear_pair_collector #(
        .DATA_W   (32),
        .MAX_PAIRS(32),
        .LEN_W    (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .bus       (bus_if),
        .collecting(collecting),
        .busy      (busy),
        .frame_done(frame_done),
        .cfg_err   (cfg_err),
        .overrun   (overrun),
        .nan_seen  (nan_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, collecting} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: busy=%b collecting=%b, want 0 0", busy, collecting);
        end
        checks++;
        if ({bus_if.m_valid, bus_if.m_last} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stream: m_valid=%b m_last=%b, want 0 0", bus_if.m_valid, bus_if.m_last);
        end
        checks++;
        if ({frame_done, cfg_err, overrun, nan_seen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: done=%b cfg=%b ovr=%b nan=%b, want 0000",
                     frame_done, cfg_err, overrun, nan_seen);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, bus_if.m_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b m_valid=%b, want 0 0", busy, bus_if.m_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w;
        start          = 1'b1;
        frame_len      = 6'd16;
        bus_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (collecting !== 1'b1 || busy !== 1'b1 || bus_if.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_collect[%0d]: collecting=%b busy=%b m_valid=%b, want 1 1 0",
                         k, collecting, busy, bus_if.m_valid);
            end
            bus_if.in_done = 1'b1;
            bus_if.in_d0   = 32'h3F80_0000 + 32'(2 * k);
            bus_if.in_d1   = 32'h3F80_0000 + 32'(2 * k + 1);
            @(negedge clk);
        end
        bus_if.in_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_w = 32'h3F80_0000 + 32'(i);
            checks++;
            if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== exp_w || bus_if.m_last !== (i == 31)) begin
                errors++;
                $display("FAIL basic_word[%0d]: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                         i, bus_if.m_valid, bus_if.m_data, bus_if.m_last, exp_w, (i == 31));
            end
            @(negedge clk);
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || bus_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: frame_done=%b busy=%b m_valid=%b, want 1 0 0",
                     frame_done, busy, bus_if.m_valid);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: frame_done=%b, want 0", frame_done);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        bit          pat [4];
        int          idx;
        int          cyc;
        exp_w = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus_if.m_ready = 1'b0;
        start     = 1'b1;
        frame_len = 6'd2;
        @(negedge clk);
        start          = 1'b0;
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = exp_w[0];
        bus_if.in_d1   = exp_w[1];
        @(negedge clk);
        bus_if.in_d0 = exp_w[2];
        bus_if.in_d1 = exp_w[3];
        @(negedge clk);
        bus_if.in_done = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            bus_if.m_ready = pat[cyc % 4];
            checks++;
            if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== exp_w[idx] || bus_if.m_last !== (idx == 3)) begin
                errors++;
                $display("FAIL bp_word[cyc %0d]: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                         cyc, bus_if.m_valid, bus_if.m_data, bus_if.m_last, exp_w[idx], (idx == 3));
            end
            if (pat[cyc % 4]) idx++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (idx != 4 || cyc != 8) begin
            errors++;
            $display("FAIL bp_count: words=%0d cycles=%0d, want 4 words in 8 cycles", idx, cyc);
        end
        checks++;
        if (frame_done !== 1'b1 || bus_if.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: frame_done=%b m_valid=%b, want 1 0", frame_done, bus_if.m_valid);
        end
        bus_if.m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cfg_err();
        logic [5:0] bad [2];
        bad = '{6'd0, 6'd33};
        for (int j = 0; j < 2; j++) begin
            start     = 1'b1;
            frame_len = bad[j];
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || collecting !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse[len %0d]: cfg_err=%b busy=%b collecting=%b, want 1 0 0",
                         bad[j], cfg_err, busy, collecting);
            end
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_clear[len %0d]: cfg_err=%b busy=%b, want 0 0", bad[j], cfg_err, busy);
            end
        end
    endtask

    task automatic test_overrun();
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'hBAD0_0000;
        bus_if.in_d1   = 32'hBAD0_0001;
        @(negedge clk);
        bus_if.in_done = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b busy=%b, want 1 0", overrun, busy);
        end
        start     = 1'b1;
        frame_len = 6'd1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (overrun !== 1'b0 || collecting !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: overrun=%b collecting=%b, want 0 1", overrun, collecting);
        end
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'h4000_0000;
        bus_if.in_d1   = 32'h4040_0000;
        @(negedge clk);
        bus_if.in_done = 1'b0;
        checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 32'h4000_0000 || bus_if.m_last !== 1'b0) begin
            errors++;
            $display("FAIL overrun_word0: valid=%b data=%h last=%b, want 1 40000000 0",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_last);
        end
        @(negedge clk);
        checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 32'h4040_0000 || bus_if.m_last !== 1'b1) begin
            errors++;
            $display("FAIL overrun_word1: valid=%b data=%h last=%b, want 1 40400000 1",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_last);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_done: frame_done=%b busy=%b overrun=%b, want 1 0 0",
                     frame_done, busy, overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_start_with_done();
        start          = 1'b1;
        frame_len      = 6'd1;
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'hDEAD_0001;
        bus_if.in_d1   = 32'hDEAD_0002;
        @(negedge clk);
        start          = 1'b0;
        bus_if.in_done = 1'b0;
        checks++;
        if (collecting !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL swd_state: collecting=%b overrun=%b, want 1 1", collecting, overrun);
        end
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'h1234_5678;
        bus_if.in_d1   = 32'h9ABC_DEF0;
        @(negedge clk);
        bus_if.in_done = 1'b0;
        checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL swd_word0: valid=%b data=%h, want 1 12345678", bus_if.m_valid, bus_if.m_data);
        end
        @(negedge clk);
        checks++;
        if (bus_if.m_data !== 32'h9ABC_DEF0 || bus_if.m_last !== 1'b1) begin
            errors++;
            $display("FAIL swd_word1: data=%h last=%b, want 9abcdef0 1", bus_if.m_data, bus_if.m_last);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL swd_done: frame_done=%b, want 1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] exp_w;
        start          = 1'b1;
        frame_len      = 6'd32;
        bus_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus_if.in_done = 1'b1;
            bus_if.in_d0   = 32'h0000_1000 + 32'(2 * k);
            bus_if.in_d1   = 32'h0000_1000 + 32'(2 * k + 1);
            @(negedge clk);
        end
        bus_if.in_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_w = 32'h0000_1000 + 32'(i);
            checks++;
            if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== exp_w) begin
                errors++;
                $display("FAIL rst_drain_word[%0d]: valid=%b data=%h, want 1 %h",
                         i, bus_if.m_valid, bus_if.m_data, exp_w);
            end
            if (i < 5) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: m_valid=%b busy=%b, want 0 0", bus_if.m_valid, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0 || bus_if.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_hold[%0d]: frame_done=%b m_valid=%b, want 0 0",
                         c, frame_done, bus_if.m_valid);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        frame_len = 6'd1;
        @(negedge clk);
        start          = 1'b0;
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'h0000_0055;
        bus_if.in_d1   = 32'h0000_0066;
        @(negedge clk);
        bus_if.in_done = 1'b0;
        checks++;
        if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== 32'h0000_0055 || bus_if.m_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_word0: valid=%b data=%h last=%b, want 1 00000055 0",
                     bus_if.m_valid, bus_if.m_data, bus_if.m_last);
        end
        @(negedge clk);
        checks++;
        if (bus_if.m_data !== 32'h0000_0066 || bus_if.m_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_after_word1: data=%h last=%b, want 00000066 1", bus_if.m_data, bus_if.m_last);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_done: frame_done=%b busy=%b, want 1 0", frame_done, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_nan();
        logic        exp_nan;
        logic [31:0] exp_w [4];
`ifdef COLLECT_NAN_FLAG_EN
        exp_nan = 1'b1;
`else
        exp_nan = 1'b0;
`endif
        exp_w = '{32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000};
        bus_if.m_ready = 1'b1;
        start          = 1'b1;
        frame_len      = 6'd2;
        @(negedge clk);
        start          = 1'b0;
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = exp_w[0];
        bus_if.in_d1   = exp_w[1];
        @(negedge clk);
        checks++;
        if (nan_seen !== 1'b0) begin
            errors++;
            $display("FAIL nan_inf: nan_seen=%b, want 0", nan_seen);
        end
        bus_if.in_d0 = exp_w[2];
        bus_if.in_d1 = exp_w[3];
        @(negedge clk);
        bus_if.in_done = 1'b0;
        checks++;
        if (nan_seen !== exp_nan) begin
            errors++;
            $display("FAIL nan_set: nan_seen=%b, want %b", nan_seen, exp_nan);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_if.m_valid !== 1'b1 || bus_if.m_data !== exp_w[i] || bus_if.m_last !== (i == 3)) begin
                errors++;
                $display("FAIL nan_word[%0d]: valid=%b data=%h last=%b, want 1 %h %b",
                         i, bus_if.m_valid, bus_if.m_data, bus_if.m_last, exp_w[i], (i == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (frame_done !== 1'b1 || nan_seen !== exp_nan) begin
            errors++;
            $display("FAIL nan_sticky: frame_done=%b nan_seen=%b, want 1 %b", frame_done, nan_seen, exp_nan);
        end
        start     = 1'b1;
        frame_len = 6'd1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (nan_seen !== 1'b0 || collecting !== 1'b1) begin
            errors++;
            $display("FAIL nan_clear: nan_seen=%b collecting=%b, want 0 1", nan_seen, collecting);
        end
        bus_if.in_done = 1'b1;
        bus_if.in_d0   = 32'h0000_0000;
        bus_if.in_d1   = 32'h0000_0000;
        @(negedge clk);
        bus_if.in_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || nan_seen !== 1'b0) begin
            errors++;
            $display("FAIL nan_clean_frame: frame_done=%b nan_seen=%b, want 1 0", frame_done, nan_seen);
        end
        @(negedge clk);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        frame_len      = '0;
        bus_if.in_done = 1'b0;
        bus_if.in_d0   = '0;
        bus_if.in_d1   = '0;
        bus_if.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_overrun();
        test_start_with_done();
        test_reset_mid_drain();
        test_nan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
